// File: rtl/fetch_to_decode_fifo_bus.sv
// Multi-entry valid/ready buffer between fetch and decode, with occupancy, almost-full and flush.
// Optional same-cycle empty bypass is enabled by defining FETCH_DECODE_FIFO_BYPASS_EN.
module fetch_to_decode_fifo_bus #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AF_THRESH = DEPTH - 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    almost_full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic [CNT_W-1:0] count_next;
    logic             empty;
    logic             bypass;
    logic             push;
    logic             pop;

    assign empty    = (count == '0);
    assign in_ready = (count != CNT_W'(DEPTH));

`ifdef FETCH_DECODE_FIFO_BYPASS_EN
    // An arriving packet is presented directly when nothing older is queued.
    assign bypass    = empty && in_valid && !flush;
    assign out_valid = !empty || bypass;
    assign out_data  = bypass ? in_data : mem[rp];
    assign push      = in_valid && in_ready && !(bypass && out_ready);
`else
    assign bypass    = 1'b0;
    assign out_valid = !empty;
    assign out_data  = mem[rp];
    assign push      = in_valid && in_ready;
`endif

    // Only stored entries are popped; a bypassed packet never touches the pointers.
    assign pop = out_ready && !empty;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wp          <= '0;
            rp          <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + PTR_W'(1);
            end
            if (pop) begin
                rp <= rp + PTR_W'(1);
            end
            count       <= count_next;
            almost_full <= (count_next >= CNT_W'(AF_THRESH));
        end
    end

    // Storage is never cleared; a flushed or reset push must not land.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) begin
            mem[wp] <= in_data;
        end
    end

    logic unused_bypass;
    assign unused_bypass = bypass;
endmodule
